// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory responder: access sizes, FSM states
// and byte-lane mask generation.
package mem_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } size_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      RESP = 2'b10
   } resp_state_t;

   // Little-endian lane enables for an access of size sz starting at byte lane.
   function automatic logic [3:0] lane_mask(input size_t sz, input logic [1:0] lane);
      logic [3:0] m;
      m = 4'b0000;
      case (sz)
         SZ_BYTE: m = 4'b0001 << lane;
         SZ_HALF: m = lane[1] ? 4'b1100 : 4'b0011;
         SZ_WORD: m = 4'b1111;
         default: m = 4'b0000;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between the CPU control/datapath (master) and the
// memory responder (slave).
interface mem_responder_if;
   logic        Req;
   logic        Wr;
   logic [1:0]  Size;
   logic [31:0] Addr;
   logic [31:0] WData;
   logic [31:0] RData;
   logic        Ready;
   logic        Busy;
   logic        AddrErr;

   modport master (
      output Req, Wr, Size, Addr, WData,
      input  RData, Ready, Busy, AddrErr
   );

   modport slave (
      input  Req, Wr, Size, Addr, WData,
      output RData, Ready, Busy, AddrErr
   );
endinterface

// File: rtl/mem_array.sv
// Word array built from four independent byte lanes: synchronous byte-enable
// write, combinational read.
module mem_array #(
   parameter int DEPTH_WORDS = 64,
   parameter int AW          = 6
) (
   input  logic          Clk,
   input  logic          we,
   input  logic [3:0]    be,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] lane_mem [DEPTH_WORDS];

         always_ff @(posedge Clk) begin
            if (we && be[gi])
               lane_mem[addr] <= wdata[gi*8 +: 8];
         end

         assign rdata[gi*8 +: 8] = lane_mem[addr];
      end
   endgenerate

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: latches a request, waits LATENCY
// cycles, commits a byte/half/word access and pulses Ready for one cycle.
module mem_responder
   import mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 64,
   parameter int LATENCY     = 2
) (
   input  logic           Clk,
   input  logic           Reset,
   mem_responder_if.slave bus
);

   localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   resp_state_t   state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic          latch_en;
   logic          wr_reg;
   size_t         size_reg;
   logic [31:0]   addr_reg;
   logic [31:0]   wdata_reg;
   logic [31:0]   rdata_reg, rdata_next;
   logic          err_reg, err_next;

   logic          commit;
   logic          req_err;
   logic          array_we;
   logic [3:0]    array_be;
   logic [31:0]   wdata_steer;
   logic [31:0]   rd_word;
   logic [31:0]   rd_shift;
   logic [31:0]   rd_ext;

   assign commit  = (state_reg == WAIT) && (cnt_reg == '0);
   assign req_err = (size_reg == SZ_RSVD)
                 || (size_reg == SZ_HALF && addr_reg[0])
                 || (size_reg == SZ_WORD && addr_reg[1:0] != 2'b00)
                 || (addr_reg[31:2] >= 30'(DEPTH_WORDS));

   // Replicate right-aligned store data onto every lane; the byte enables pick the live ones.
   always_comb begin
      case (size_reg)
         SZ_BYTE: wdata_steer = {4{wdata_reg[7:0]}};
         SZ_HALF: wdata_steer = {2{wdata_reg[15:0]}};
         default: wdata_steer = wdata_reg;
      endcase
   end

   assign array_we = commit && wr_reg && !req_err;
   assign array_be = lane_mask(size_reg, addr_reg[1:0]);

   mem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_array (
      .Clk   (Clk),
      .we    (array_we),
      .be    (array_be),
      .addr  (addr_reg[AW+1:2]),
      .wdata (wdata_steer),
      .rdata (rd_word)
   );

   assign rd_shift = rd_word >> {addr_reg[1:0], 3'b000};

   always_comb begin
      case (size_reg)
         SZ_BYTE: rd_ext = {24'b0, rd_shift[7:0]};
         SZ_HALF: rd_ext = {16'b0, rd_shift[15:0]};
         default: rd_ext = rd_shift;
      endcase
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      latch_en   = 1'b0;
      rdata_next = rdata_reg;
      err_next   = err_reg;
      case (state_reg)
         IDLE: begin
            if (bus.Req) begin
               state_next = WAIT;
               cnt_next   = CW'(LATENCY - 1);
               latch_en   = 1'b1;
            end
         end
         WAIT: begin
            if (cnt_reg != '0) begin
               cnt_next = cnt_reg - 1'b1;
            end else begin
               state_next = RESP;
               err_next   = req_err;
               if (req_err)
                  rdata_next = '0;
               else if (!wr_reg)
                  rdata_next = rd_ext;
            end
         end
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         rdata_reg <= '0;
         err_reg   <= 1'b0;
         wr_reg    <= 1'b0;
         size_reg  <= SZ_BYTE;
         addr_reg  <= '0;
         wdata_reg <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         rdata_reg <= rdata_next;
         err_reg   <= err_next;
         if (latch_en) begin
            wr_reg    <= bus.Wr;
            size_reg  <= size_t'(bus.Size);
            addr_reg  <= bus.Addr;
            wdata_reg <= bus.WData;
         end
      end
   end

   assign bus.Ready   = (state_reg == RESP);
   assign bus.Busy    = (state_reg != IDLE);
   assign bus.AddrErr = (state_reg == RESP) && err_reg;
   assign bus.RData   = rdata_reg;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus random
// traffic checked against a byte-addressed reference memory.
module tb_mem_responder;

   localparam int DEPTH = 64;
   localparam int LAT   = 2;

   logic Clk   = 1'b0;
   logic Reset = 1'b1;

   mem_responder_if bus();

   mem_responder #(
      .DEPTH_WORDS (DEPTH),
      .LATENCY     (LAT)
   ) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 Clk = ~Clk;

   int checks   = 0;
   int failures = 0;
   logic [7:0] ref_mem [DEPTH*4];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit ref_err(input logic [1:0] sz, input logic [31:0] a);
      return (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) ||
             (sz == 2'd2 && a % 4 != 0) || (a / 4 >= DEPTH);
   endfunction

   task automatic do_req(input bit wr, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, input bit noise);
      logic [31:0] exp_rd;
      bit          exp_err;
      int          nb;
      int          k;
      exp_err = ref_err(sz, a);
      exp_rd  = '0;
      nb      = 1 << sz;
      if (!exp_err) begin
         for (int i = 0; i < nb; i++) begin
            if (wr) ref_mem[int'(a) + i] = wd[8*i +: 8];
            else    exp_rd = exp_rd | (32'(ref_mem[int'(a) + i]) << (8*i));
         end
      end
      bus.Req = 1'b1; bus.Wr = wr; bus.Size = sz; bus.Addr = a; bus.WData = wd;
      @(posedge Clk);
      #1;
      bus.Req = 1'b0;
      if (noise) begin
         bus.Wr = ~wr; bus.Size = 2'($urandom); bus.Addr = $urandom; bus.WData = $urandom;
      end
      k = 0;
      while (k < 20) begin
         @(negedge Clk);
         if (bus.Ready === 1'b1) break;
         check("busy_wait", 32'(bus.Busy), 32'd1);
         if (noise) begin
            bus.Req = ~bus.Req; bus.Addr = $urandom; bus.Wr = 1'($urandom);
            bus.Size = 2'($urandom); bus.WData = $urandom;
         end
         k++;
      end
      check("latency", 32'(k), 32'(LAT));
      check("resp_busy", 32'(bus.Busy), 32'd1);
      check("resp_err", 32'(bus.AddrErr), 32'(exp_err));
      if (!wr || exp_err) check("resp_rdata", bus.RData, exp_rd);
      $display("txn wr=%0d size=%0d addr=%h wdata=%h rdata=%h err=%0b cycles=%0d",
               wr, sz, a, wd, bus.RData, bus.AddrErr, k);
      @(negedge Clk);
      bus.Req = 1'b0;
      check("ready_pulse", 32'(bus.Ready), 32'd0);
      check("idle_busy", 32'(bus.Busy), 32'd0);
      check("idle_err", 32'(bus.AddrErr), 32'd0);
      if (!wr || exp_err) check("rdata_hold", bus.RData, exp_rd);
   endtask

   initial begin
      logic [31:0] a;
      logic [1:0]  sz;
      bus.Req = 1'b0; bus.Wr = 1'b0; bus.Size = 2'd0; bus.Addr = '0; bus.WData = '0;
      @(negedge Clk);
      @(negedge Clk);
      check("rst_ready", 32'(bus.Ready), 32'd0);
      check("rst_busy", 32'(bus.Busy), 32'd0);
      check("rst_err", 32'(bus.AddrErr), 32'd0);
      check("rst_rdata", bus.RData, 32'd0);
      Reset = 1'b0;
      @(negedge Clk);

      // Give every word a known value so the model covers the whole array.
      for (int w = 0; w < DEPTH; w++) do_req(1'b1, 2'd2, 32'(w * 4), 32'd0, 1'b0);

      do_req(1'b1, 2'd2, 32'h10, 32'hDEADBEEF, 1'b0);
      do_req(1'b0, 2'd2, 32'h10, 32'h0, 1'b0);
      do_req(1'b0, 2'd0, 32'h11, 32'h0, 1'b0);
      do_req(1'b1, 2'd1, 32'h12, 32'h00001234, 1'b0);
      do_req(1'b0, 2'd2, 32'h10, 32'h0, 1'b0);
      check("half_merge", bus.RData, 32'h1234BEEF);
      do_req(1'b0, 2'd2, 32'h13, 32'h0, 1'b0);
      do_req(1'b1, 2'd2, 32'(DEPTH * 4), 32'hCAFEF00D, 1'b0);
      do_req(1'b0, 2'd2, 32'h0, 32'h0, 1'b0);
      do_req(1'b1, 2'd3, 32'h20, 32'h55555555, 1'b0);
      do_req(1'b1, 2'd1, 32'h21, 32'h0000AAAA, 1'b0);
      do_req(1'b0, 2'd2, 32'h20, 32'h0, 1'b0);

      // Reset in WAIT must drop the pending store.
      bus.Req = 1'b1; bus.Wr = 1'b1; bus.Size = 2'd2; bus.Addr = 32'h10; bus.WData = 32'hFFFFFFFF;
      @(posedge Clk);
      #1;
      bus.Req = 1'b0;
      @(negedge Clk);
      check("wait_busy", 32'(bus.Busy), 32'd1);
      Reset = 1'b1;
      #1;
      check("arst_ready", 32'(bus.Ready), 32'd0);
      check("arst_busy", 32'(bus.Busy), 32'd0);
      check("arst_err", 32'(bus.AddrErr), 32'd0);
      check("arst_rdata", bus.RData, 32'd0);
      @(negedge Clk);
      @(negedge Clk);
      Reset = 1'b0;
      @(negedge Clk);
      do_req(1'b0, 2'd2, 32'h10, 32'h0, 1'b0);
      check("abandoned_store", bus.RData, 32'h1234BEEF);

      for (int n = 0; n < 10; n++)
         do_req(1'($urandom), 2'($urandom_range(0, 2)), 32'($urandom_range(0, DEPTH*4 - 1)) & ~32'h3,
                $urandom, 1'b1);

      for (int n = 0; n < 150; n++) begin
         sz = 2'($urandom_range(0, 3));
         a  = 32'($urandom_range(0, DEPTH*4 + 15));
         if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~32'((1 << sz) - 1);
         do_req(1'($urandom), sz, a, $urandom, 1'($urandom_range(0, 3) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the multicycle MIPS CPU: it services load/store requests issued by the control unit and datapath. It accepts one request at a time through a Req/Ready handshake, waits a programmable latency, performs the byte/half/word access on an internal word array, and returns read data. Little-endian. Read data is zero-extended; the datapath performs any sign extension.

## Interface
Parameters:
- DEPTH_WORDS, 64: number of 32-bit words in the array. Word index is Addr[31:2].
- LATENCY, 2: number of wait cycles before the access. Legal values are ≥1.

Ports:
- Clk  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- Req  in  1  request strobe; sampled only in IDLE
- Wr  in  1  1 = store, 0 = load
- Size  in  2  00 byte, 01 half, 10 word, 11 reserved
- Addr  in  32  byte address
- WData  in  32  store data, right-aligned (bits 7:0 for a byte, 15:0 for a half)
- RData  out  32  load data, right-aligned and zero-extended; valid while Ready=1
- Ready  out  1  one-cycle completion pulse
- Busy  out  1  high in WAIT and RESP
- AddrErr  out  1  error flag; valid while Ready=1

Clock and reset: one clock; reset is asynchronous and active-high.

## Operation
- States are IDLE, WAIT and RESP.
- **IDLE:**
  - Busy=0.
  - If Req=1 at the clock edge, latch Wr, Size, Addr and WData, load cnt=LATENCY-1, and go to WAIT.
  - Otherwise stay in IDLE.
- **WAIT:**
  - Busy=1.
  - If cnt≠0, decrement cnt.
  - If cnt=0, commit the access at this edge and go to RESP.
  - Req and all other inputs are ignored; the latched request is used.
- **Commit:**
  - Store: write only the addressed lanes.
    - Byte: lane Addr[1:0].
    - Half: lanes {Addr[1],0} and {Addr[1],1}.
    - Word: all 4 lanes.
  - Load: register the selected lanes shifted to bit 0, upper bits zero.
- **Error:** the request is an error if any of these holds:
  - Size=11.
  - Half with Addr[0]=1.
  - Word with Addr[1:0]≠0.
  - Addr[31:2] ≥ DEPTH_WORDS.

  On error: the array is unchanged, RData=0 and AddrErr=1.
- **RESP:**
  - Ready=1 and Busy=1 for exactly one cycle.
  - RData and AddrErr are held at their committed values.
  - Always go to IDLE next. Req high during RESP is not accepted; it is re-sampled in IDLE.
- Outside RESP: RData holds its last value and AddrErr=0.
- **Reset:**
  - Outputs: state=IDLE, cnt=0, RData=0, Ready=0, Busy=0, AddrErr=0.
  - The array is not cleared.
  - Reset during WAIT abandons the request; a pending store is never committed.

## Timing
- Req sampled at edge E0 → WAIT occupies LATENCY cycles → commit at edge E0+LATENCY → Ready high in the cycle after edge E0+LATENCY.
- Example with LATENCY=2: Req high in cycle 0, Ready high in cycle 3.
- Minimum request-to-request spacing is LATENCY+2 cycles: Req in the IDLE cycle immediately after RESP is accepted.
- A store is visible to any later load. There is no read-during-write hazard because only one access is outstanding.
- The array uses a synchronous write and a combinational read. Load data is registered at the commit edge.

## Structure
- Package mem_pkg:
  - enum size_t: SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD.
  - enum resp_state_t: IDLE, WAIT, RESP.
  - function for lane-mask generation.
- Sub-module mem_array:
  - DEPTH_WORDS×32 storage.
  - 4-bit byte-enable write port.
  - Combinational read port.
- mem_responder contains the FSM, the request latch, the latency counter, error detection, lane steering and zero-extension.

## Test plan
- **Store word, then load word:** store word 0xDEADBEEF @0x10 (LATENCY=2), then load word @0x10 → Ready pulse in cycle 3 after each Req; RData=0xDEADBEEF; AddrErr=0.
- **Byte load:** load byte @0x11 after the store above → RData=0x000000BE.
- **Half store:** store half 0x1234 @0x12, then load word @0x10 → RData=0x1234BEEF.
- **Error cases:**
  - Load word @0x13 → Ready with AddrErr=1, RData=0.
  - Store word @(DEPTH_WORDS×4) → AddrErr=1; array unchanged.
- **Reset during WAIT:** assert Reset in WAIT of a store 0xFFFFFFFF @0x10 → all outputs 0 immediately; a later load word @0x10 returns 0x1234BEEF.
- **Req while busy:** toggle Req every cycle while Busy=1 → no extra Ready pulses; exactly one Ready per request accepted in IDLE.
